// File: rtl/car_sensor_conditioner_pkg.sv
// car_sensor_conditioner_pkg: light encodings shared with the traffic-light controller and conditioner states
package car_sensor_conditioner_pkg;
   typedef enum logic [1:0] {RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2} light_t;
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVE = 2'd2, DROP = 2'd3} cond_state_t;
endpackage

// File: rtl/car_sensor_conditioner_if.sv
// car_sensor_conditioner_if: loop sensor, country light and conditioner outputs
interface car_sensor_conditioner_if #(parameter int CNT_W = 4);
   import car_sensor_conditioner_pkg::*;
   logic loop_raw;
   light_t cntry;
   logic X;
   logic [CNT_W-1:0] car_count;
   logic det;
   logic fault;
   modport master (output loop_raw, cntry, input X, car_count, det, fault);
   modport slave (input loop_raw, cntry, output X, car_count, det, fault);
endinterface

// File: rtl/car_sensor_conditioner_sensor_debounce.sv
// sensor_debounce: two-flop synchronizer and debounce counter producing a clean detector level
module sensor_debounce #(
   parameter int DEBOUNCE = 4
) (
   input  logic clock,
   input  logic clear_n,
   input  logic loop_raw,
   output logic det
);
   localparam int DW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
   logic [1:0] sync_q;
   logic [DW-1:0] dcnt;
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         sync_q <= '0;
         dcnt <= '0;
         det <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], loop_raw};
         if (sync_q[1] == det)
            dcnt <= '0;
         else if (dcnt == DW'(DEBOUNCE - 1)) begin
            det <= sync_q[1];
            dcnt <= '0;
         end else
            dcnt <= dcnt + 1'b1;
      end
   end
endmodule

// File: rtl/car_sensor_conditioner.sv
// car_sensor_conditioner: turns the country loop detector into a held, bounded car-present request X
module car_sensor_conditioner
   import car_sensor_conditioner_pkg::*;
#(
   parameter int DEBOUNCE     = 4,
   parameter int MIN_GREEN    = 8,
   parameter int MAX_EXT      = 16,
   parameter int STUCK_CYCLES = 1024,
   parameter int CNT_W        = 4
) (
   input logic clock,
   input logic clear_n,
   car_sensor_conditioner_if.slave bus
);
   localparam int TW = (MIN_GREEN + MAX_EXT) > 1 ? $clog2(MIN_GREEN + MAX_EXT) : 1;
   localparam int SW = STUCK_CYCLES > 1 ? $clog2(STUCK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   cond_state_t state, state_nxt;
   logic [TW-1:0] timer;
   logic [SW-1:0] scnt;
   logic [CNT_W-1:0] car_count;
   logic det, det_q, fault, det_rise, stuck, min_done, max_done, serve_entry;
   sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
      .clock(clock),
      .clear_n(clear_n),
      .loop_raw(bus.loop_raw),
      .det(det)
   );
   assign det_rise = det & ~det_q & ~fault;
   assign stuck = det & (scnt == SW'(STUCK_CYCLES - 1));
   assign min_done = timer >= TW'(MIN_GREEN - 1);
   assign max_done = timer == TW'(MIN_GREEN + MAX_EXT - 1);
   assign serve_entry = state == REQ && state_nxt == SERVE;
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = det_rise ? REQ : IDLE;
         REQ:     state_nxt = bus.cntry == GREEN ? SERVE : REQ;
         SERVE:   state_nxt = (min_done && !det) ? IDLE : max_done ? DROP : SERVE;
         DROP:    state_nxt = bus.cntry == RED ? (det ? REQ : IDLE) : DROP;
         default: state_nxt = IDLE;
      endcase
      if (fault || stuck) state_nxt = IDLE;
   end
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state <= IDLE;
         timer <= '0;
         scnt <= '0;
         det_q <= 1'b0;
         fault <= 1'b0;
         car_count <= '0;
      end else begin
         state <= state_nxt;
         det_q <= det;
         timer <= (state == SERVE && !max_done) ? timer + 1'b1 : '0;
         scnt <= !det ? '0 : (scnt == SW'(STUCK_CYCLES - 1)) ? scnt : scnt + 1'b1;
         if (stuck) fault <= 1'b1;
         if (!fault)
            car_count <= serve_entry ? CNT_W'(det_rise) :
                         (det_rise && car_count != CNT_MAX) ? car_count + 1'b1 : car_count;
      end
   end
   assign bus.X = state == REQ || state == SERVE;
   assign bus.car_count = car_count;
   assign bus.det = det;
   assign bus.fault = fault;
endmodule

// File: tb/tb_car_sensor_conditioner.sv
// tb_car_sensor_conditioner: directed scoreboard bench for the country-road sensor conditioner
module tb_car_sensor_conditioner;
   import car_sensor_conditioner_pkg::*;
   localparam int DEBOUNCE = 4, MIN_GREEN = 8, MAX_EXT = 16, STUCK_CYCLES = 64, CNT_W = 4;
   typedef struct packed {
      logic x;
      logic det;
      logic [CNT_W-1:0] cnt;
      logic fault;
   } exp_t;
   logic clock = 1'b0;
   logic clear_n = 1'b0;
   exp_t sb[$];
   string tag_q[$];
   int total = 0;
   int bad = 0;
   car_sensor_conditioner_if #(.CNT_W(CNT_W)) bus ();
   car_sensor_conditioner #(
      .DEBOUNCE(DEBOUNCE),
      .MIN_GREEN(MIN_GREEN),
      .MAX_EXT(MAX_EXT),
      .STUCK_CYCLES(STUCK_CYCLES),
      .CNT_W(CNT_W)
   ) dut (
      .clock(clock),
      .clear_n(clear_n),
      .bus(bus)
   );
   always #5 clock = ~clock;
   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask
   function automatic void push(input string tag, input logic x, input logic d, input logic [CNT_W-1:0] c, input logic f);
      exp_t e;
      e.x = x;
      e.det = d;
      e.cnt = c;
      e.fault = f;
      sb.push_back(e);
      tag_q.push_back(tag);
   endfunction
   task automatic cmp(input string tag, input string field, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
      end
   endtask
   task automatic check();
      exp_t e;
      string tag;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL scoreboard empty at check");
         return;
      end
      e = sb.pop_front();
      tag = tag_q.pop_front();
      cmp(tag, "X", 8'(bus.X), 8'(e.x));
      cmp(tag, "det", 8'(bus.det), 8'(e.det));
      cmp(tag, "car_count", 8'(bus.car_count), 8'(e.cnt));
      cmp(tag, "fault", 8'(bus.fault), 8'(e.fault));
   endtask
   task automatic check_state(input string tag, input cond_state_t exp);
      cmp(tag, "state", 8'(dut.state), 8'(exp));
   endtask
   task automatic pulse();
      bus.loop_raw = 1'b1;
      tick(6);
      bus.loop_raw = 1'b0;
      tick(6);
   endtask
   initial begin
      bus.loop_raw = 1'b0;
      bus.cntry = RED;
      push("reset", 1'b0, 1'b0, 4'd0, 1'b0);
      tick(2);
      check();
      clear_n = 1'b1;
      bus.loop_raw = 1'b1;
      push("glitch", 1'b0, 1'b0, 4'd0, 1'b0);
      tick(3);
      bus.loop_raw = 1'b0;
      tick(10);
      check();
      bus.loop_raw = 1'b1;
      push("lat_pre", 1'b0, 1'b1, 4'd0, 1'b0);
      push("lat_x", 1'b1, 1'b1, 4'd1, 1'b0);
      tick(DEBOUNCE + 2);
      check();
      tick(1);
      check();
      tick(5);
      bus.cntry = GREEN;
      bus.loop_raw = 1'b0;
      push("serve_entry", 1'b1, 1'b1, 4'd0, 1'b0);
      push("min_last", 1'b1, 1'b0, 4'd0, 1'b0);
      push("min_end", 1'b0, 1'b0, 4'd0, 1'b0);
      tick(1);
      check();
      tick(MIN_GREEN - 1);
      check();
      tick(1);
      check();
      check_state("min_end", IDLE);
      bus.cntry = RED;
      bus.loop_raw = 1'b1;
      push("ext_req", 1'b1, 1'b1, 4'd1, 1'b0);
      tick(DEBOUNCE + 3);
      check();
      bus.cntry = GREEN;
      push("ext_last", 1'b1, 1'b1, 4'd0, 1'b0);
      push("ext_drop", 1'b0, 1'b1, 4'd0, 1'b0);
      tick(1 + MIN_GREEN + MAX_EXT - 1);
      check();
      tick(1);
      check();
      check_state("ext_drop", DROP);
      bus.cntry = YELLOW;
      push("drop_yellow", 1'b0, 1'b1, 4'd0, 1'b0);
      tick(3);
      check();
      check_state("drop_yellow", DROP);
      bus.cntry = RED;
      push("drop_rereq", 1'b1, 1'b1, 4'd0, 1'b0);
      tick(1);
      check();
      check_state("drop_rereq", REQ);
      clear_n = 1'b0;
      bus.loop_raw = 1'b0;
      push("clr_req", 1'b0, 1'b0, 4'd0, 1'b0);
      tick(1);
      check();
      clear_n = 1'b1;
      push("cnt3", 1'b1, 1'b0, 4'd3, 1'b0);
      repeat (3) pulse();
      tick(10);
      check();
      push("cnt15", 1'b1, 1'b0, 4'd15, 1'b0);
      repeat (12) pulse();
      tick(10);
      check();
      push("cnt_sat", 1'b1, 1'b0, 4'd15, 1'b0);
      repeat (5) pulse();
      tick(10);
      check();
      bus.cntry = GREEN;
      push("cnt_clear", 1'b1, 1'b0, 4'd0, 1'b0);
      tick(1);
      check();
      bus.cntry = RED;
      push("cnt_idle", 1'b0, 1'b0, 4'd0, 1'b0);
      tick(10);
      check();
      clear_n = 1'b0;
      tick(1);
      clear_n = 1'b1;
      bus.loop_raw = 1'b1;
      push("stuck_pre", 1'b1, 1'b1, 4'd1, 1'b0);
      push("stuck_set", 1'b0, 1'b1, 4'd1, 1'b1);
      tick(DEBOUNCE + 2 + STUCK_CYCLES - 1);
      check();
      tick(1);
      check();
      bus.loop_raw = 1'b0;
      tick(8);
      bus.loop_raw = 1'b1;
      push("stuck_ignore", 1'b0, 1'b1, 4'd1, 1'b1);
      tick(10);
      check();
      check_state("stuck_ignore", IDLE);
      clear_n = 1'b0;
      bus.loop_raw = 1'b0;
      push("clr_fault", 1'b0, 1'b0, 4'd0, 1'b0);
      tick(1);
      check();
      clear_n = 1'b1;
      bus.loop_raw = 1'b1;
      push("mid_req", 1'b1, 1'b1, 4'd1, 1'b0);
      tick(DEBOUNCE + 3);
      check();
      bus.cntry = GREEN;
      push("mid_serve", 1'b1, 1'b1, 4'd0, 1'b0);
      tick(3);
      check();
      check_state("mid_serve", SERVE);
      clear_n = 1'b0;
      bus.loop_raw = 1'b0;
      push("clr_serve", 1'b0, 1'b0, 4'd0, 1'b0);
      tick(1);
      check();
      check_state("clr_serve", IDLE);
      clear_n = 1'b1;
      bus.cntry = RED;
      push("post_clr", 1'b0, 1'b0, 4'd0, 1'b0);
      tick(12);
      check();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/car_sensor_conditioner.md
Name: car_sensor_conditioner

Overview:
- Upstream stage of the highway/country traffic-light controller. It produces that controller's country-road car-present request `X`.
- Takes the raw, asynchronous country-road loop-detector signal, synchronizes and debounces it, and latches a service request.
- Holds the request for a guaranteed minimum country green, bounded by a maximum extension.
- Counts waiting cars and flags a stuck-high sensor.

Parameters:
- DEBOUNCE, 4, consecutive cycles the synchronized input must differ from the debounced value before the debounced value flips (≥1).
- MIN_GREEN, 8, minimum cycles `X` stays high once the country light is GREEN.
- MAX_EXT, 16, maximum extra cycles beyond MIN_GREEN that `X` is held while a car is still present.
- STUCK_CYCLES, 1024, consecutive debounced-high cycles that declare the sensor faulty.
- CNT_W, 4, width of car_count.

Ports:
- clock  in  1  system clock, rising edge
- clear_n  in  1  synchronous active-low reset
- loop_raw  in  1  raw loop detector, asynchronous to clock
- cntry  in  2  country light currently driven by the controller (RED=0, YELLOW=1, GREEN=2)
- X  out  1  car-present request to the traffic-light controller
- car_count  out  CNT_W  cars detected since last service, saturating
- det  out  1  debounced sensor level (observability)
- fault  out  1  sticky stuck-sensor flag

Behaviour:
- Reset: one clock, synchronous active-low reset; clear_n sampled low at a rising edge resets everything.
  - X=0, det=0, car_count=0, fault=0.
  - Both synchronizer flops and all counters cleared; FSM=IDLE.
  - Reset at any point, including mid-SERVE, takes effect on the next edge with no residue.
- Synchronizer: 2 flops on loop_raw → sync.
- Debounce:
  - dcnt counts cycles where sync≠det; dcnt clears whenever sync==det.
  - When sync≠det and dcnt==DEBOUNCE-1: det<=sync, dcnt<=0.
  - Pulses shorter than DEBOUNCE cycles at sync are ignored.
- det_rise = det registered 0→1. Steady loop_raw edge → det change is 2+DEBOUNCE cycles.
- FSM (Moore; X=1 in REQ and SERVE only):
  - IDLE: det_rise → REQ.
  - REQ: cntry==GREEN → SERVE, timer<=0.
  - SERVE: timer increments each cycle.
    - timer≥MIN_GREEN-1 and det==0 → IDLE.
    - Else timer==MIN_GREEN+MAX_EXT-1 → DROP.
    - Guarantees X high for ≥MIN_GREEN and ≤MIN_GREEN+MAX_EXT cycles counted from SERVE entry.
  - DROP: X=0 so the controller leaves country green. On cntry==RED: det==1 → REQ, else IDLE.
  - Unused encodings → IDLE.
- Latency: loop_raw steady high → X high after DEBOUNCE+3 cycles (2 synchronizer + DEBOUNCE debounce + 1 FSM register).
- car_count:
  - +1 on det_rise, saturating at 2^CNT_W-1.
  - Cleared on the REQ→SERVE transition.
  - If det_rise coincides with SERVE entry, car_count=1.
- Stuck detection:
  - scnt counts consecutive det==1 cycles; clears when det==0; saturates.
  - When scnt reaches STUCK_CYCLES-1 with det still 1: fault<=1 (sticky until reset).
  - While fault=1: FSM forced to IDLE, det_rise ignored, X=0, car_count frozen.
- Counter widths via $clog2 of their maximum value; no wrap anywhere.
- Simultaneous det fall and MIN_GREEN expiry → IDLE, not DROP.

Decomposition:
- Shared package: light encodings RED/YELLOW/GREEN (2-bit), shared with the traffic-light controller; conditioner state enum {IDLE, REQ, SERVE, DROP}.
- One sub-module: sensor_debounce (synchronizer + debounce counter, params DEBOUNCE, ports clock, clear_n, loop_raw → det).
- FSM, counters and fault logic stay in the top.

Test Plan:
- Glitch reject: loop_raw high 3 cycles (DEBOUNCE=4), cntry=RED → det, X stay 0; car_count=0.
- Request latency: loop_raw high and held, cntry=RED → X rises exactly 7 cycles after the input edge; car_count=1.
- Min hold: from the previous test, cntry=GREEN 5 cycles after X rises, loop_raw low immediately → X stays high 8 cycles from SERVE entry, then 0; state IDLE; car_count=0.
- Max extension: loop_raw held high, cntry=GREEN → X falls after 24 SERVE cycles (DROP).
  - Drive cntry YELLOW 3 cycles then RED → X=1 one cycle after RED.
- Counting: cntry=RED, 3 pulses (6 high/6 low) → car_count=3.
  - 20 pulses → car_count=15 (saturated).
  - cntry=GREEN → car_count=0.
- Stuck/reset:
  - STUCK_CYCLES=64, loop_raw high, cntry=RED → fault=1 and X=0 at the 64th det-high cycle; new pulses ignored.
  - clear_n low one cycle → fault, X, car_count, det all 0 at the next edge.
  - Repeat the clear_n pulse mid-SERVE → same result.
